// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared MEM-stage definitions: datapath widths, controller state encoding and
// the byte-address to SRAM half-word address mapping.
package mem_stage_sram_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_LO   = 2'd1,
    MEM_HI   = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  // Half-word address of the low half of the word holding byte address addr.
  function automatic logic [DATA_W-1:0] lo_half_addr(input logic [DATA_W-1:0] addr,
                                                     input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] wa;
    wa = (addr - base) >> 2;
    return wa << 1;
  endfunction
endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// EXE/MEM -> MEM/WB pipeline signals plus the 16-bit external SRAM bus.
interface mem_stage_sram_ctrl_if #(parameter int SRAM_AW = 18);
  import mem_stage_sram_ctrl_pkg::*;

  logic                           WB_en_in;
  logic                           MEM_R_EN_in;
  logic                           MEM_W_EN_in;
  logic        [DATA_W-1:0]       ALU_result_in;
  logic        [DATA_W-1:0]       ST_val_in;
  logic        [REG_AW-1:0]       Dest_in;
  logic                           WB_en_out;
  logic                           MEM_R_EN_out;
  logic        [DATA_W-1:0]       ALU_result_out;
  logic        [DATA_W-1:0]       Mem_read_value;
  logic        [REG_AW-1:0]       Dest_out;
  logic                           freeze;
  logic        [SRAM_AW-1:0]      SRAM_ADDR;
  logic        [HALF_W-1:0]       SRAM_DQ_out;
  logic        [HALF_W-1:0]       SRAM_DQ_in;
  logic                           SRAM_DQ_oe;
  logic                           SRAM_WE_N;

  modport master (
    output WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in, SRAM_DQ_in,
    input  WB_en_out, MEM_R_EN_out, ALU_result_out, Mem_read_value, Dest_out, freeze,
           SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  modport slave (
    input  WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in, SRAM_DQ_in,
    output WB_en_out, MEM_R_EN_out, ALU_result_out, Mem_read_value, Dest_out, freeze,
           SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );
endinterface

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// WAIT_CYCLES-modulo counter: clears while idle, flags the last cycle of each half-word transfer.
module mem_wait_counter #(
  parameter  int WAIT_CYCLES = 1,
  localparam int CW          = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(WAIT_CYCLES - 1));
  assign o_last = w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: passes ALU ops straight through, runs loads/stores as two SRAM
// half-word transfers while holding freeze, then presents the result in DONE.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  mem_stage_sram_ctrl_if.slave bus
);
  mem_state_e          r_state;
  logic [SRAM_AW-1:0]  r_sram_addr;
  logic [HALF_W-1:0]   r_dq_out;
  logic                r_we_n;
  logic                r_oe;
  logic [DATA_W-1:0]   r_st_val;
  logic [DATA_W-1:0]   r_alu;
  logic [REG_AW-1:0]   r_dest;
  logic                r_wb_en;
  logic                r_rd_req;
  logic                r_wr;
  logic [HALF_W-1:0]   r_rd_lo;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_req;
  logic                w_wr;
  logic                w_idle;
  logic                w_busy;
  logic                w_done;
  logic                w_freeze;
  logic                w_last;
  logic [SRAM_AW-1:0]  w_lo_addr;

  assign w_req     = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
  // A simultaneous read and write request is serviced as a read.
  assign w_wr      = bus.MEM_W_EN_in & ~bus.MEM_R_EN_in;
  assign w_idle    = (r_state == MEM_IDLE);
  assign w_busy    = (r_state == MEM_LO) || (r_state == MEM_HI);
  assign w_done    = (r_state == MEM_DONE);
  assign w_freeze  = (w_idle & w_req) | w_busy;
  assign w_lo_addr = SRAM_AW'(lo_half_addr(bus.ALU_result_in, ADDR_BASE));

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .i_clr (~w_busy),
    .i_en  (w_busy),
    .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MEM_IDLE;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_we_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_st_val    <= '0;
      r_alu       <= '0;
      r_dest      <= '0;
      r_wb_en     <= 1'b0;
      r_rd_req    <= 1'b0;
      r_wr        <= 1'b0;
      r_rd_lo     <= '0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_req) begin
            r_state     <= MEM_LO;
            r_sram_addr <= w_lo_addr;
            r_dq_out    <= bus.ST_val_in[HALF_W-1:0];
            r_we_n      <= ~w_wr;
            r_oe        <= w_wr;
            r_st_val    <= bus.ST_val_in;
            r_alu       <= bus.ALU_result_in;
            r_dest      <= bus.Dest_in;
            r_wb_en     <= bus.WB_en_in;
            r_rd_req    <= bus.MEM_R_EN_in;
            r_wr        <= w_wr;
          end
        end
        MEM_LO: begin
          if (w_last) begin
            r_state     <= MEM_HI;
            r_sram_addr <= {r_sram_addr[SRAM_AW-1:1], 1'b1};
            r_dq_out    <= r_st_val[DATA_W-1:HALF_W];
            if (!r_wr) r_rd_lo <= bus.SRAM_DQ_in;
          end
        end
        MEM_HI: begin
          if (w_last) begin
            r_state <= MEM_DONE;
            r_we_n  <= 1'b1;
            r_oe    <= 1'b0;
            if (!r_wr) r_rd_data <= {bus.SRAM_DQ_in, r_rd_lo};
          end
        end
        MEM_DONE: r_state <= MEM_IDLE;
        default:  r_state <= MEM_IDLE;
      endcase
    end
  end

  // In IDLE the stage is transparent; otherwise the latched instruction is presented.
  assign bus.freeze         = w_freeze;
  assign bus.WB_en_out      = w_idle ? (bus.WB_en_in & ~w_freeze) : (w_done & r_wb_en);
  assign bus.MEM_R_EN_out   = w_idle ? bus.MEM_R_EN_in   : r_rd_req;
  assign bus.ALU_result_out = w_idle ? bus.ALU_result_in : r_alu;
  assign bus.Dest_out       = w_idle ? bus.Dest_in       : r_dest;
  assign bus.Mem_read_value = r_rd_data;
  assign bus.SRAM_ADDR      = r_sram_addr;
  assign bus.SRAM_DQ_out    = r_dq_out;
  assign bus.SRAM_WE_N      = r_we_n;
  assign bus.SRAM_DQ_oe     = r_oe;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: one instance with WAIT_CYCLES=1, one with 3.
module tb_mem_stage_sram_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.SRAM_AW(18)) bus1 ();
  mem_stage_sram_ctrl_if #(.SRAM_AW(18)) bus3 ();

  mem_stage_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  mem_stage_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  logic [15:0] mem1 [16];
  logic [15:0] mem3 [16];

  always @(posedge clk) if (!bus1.SRAM_WE_N) mem1[bus1.SRAM_ADDR[3:0]] <= bus1.SRAM_DQ_out;
  always @(posedge clk) if (!bus3.SRAM_WE_N) mem3[bus3.SRAM_ADDR[3:0]] <= bus3.SRAM_DQ_out;
  assign bus1.SRAM_DQ_in = mem1[bus1.SRAM_ADDR[3:0]];
  assign bus3.SRAM_DQ_in = mem3[bus3.SRAM_ADDR[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] st, input logic [4:0] dest);
    bus1.WB_en_in = wb; bus1.MEM_R_EN_in = r; bus1.MEM_W_EN_in = w;
    bus1.ALU_result_in = alu; bus1.ST_val_in = st; bus1.Dest_in = dest;
  endtask

  task automatic drive3(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] st, input logic [4:0] dest);
    bus3.WB_en_in = wb; bus3.MEM_R_EN_in = r; bus3.MEM_W_EN_in = w;
    bus3.ALU_result_in = alu; bus3.ST_val_in = st; bus3.Dest_in = dest;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive1(0, 0, 0, 0, 0, 0);
    drive3(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_freeze", 32'(bus1.freeze), 0);
    chk("rst_we_n", 32'(bus1.SRAM_WE_N), 1);
    chk("rst_oe", 32'(bus1.SRAM_DQ_oe), 0);
    chk("rst_rdval", bus1.Mem_read_value, 0);
    chk("rst_freeze3", 32'(bus3.freeze), 0);
    @(negedge clk); rst = 1'b0;

    // ALU op passes straight through
    @(negedge clk); drive1(1, 0, 0, 32'h55, 0, 5'd7); #1;
    chk("alu_wb", 32'(bus1.WB_en_out), 1);
    chk("alu_res", bus1.ALU_result_out, 32'h55);
    chk("alu_dest", 32'(bus1.Dest_out), 7);
    chk("alu_rd", 32'(bus1.MEM_R_EN_out), 0);
    chk("alu_freeze", 32'(bus1.freeze), 0);
    chk("alu_we_n", 32'(bus1.SRAM_WE_N), 1);

    // Store 0xDEADBEEF at 1024
    @(negedge clk); drive1(1, 0, 1, 32'd1024, 32'hDEADBEEF, 5'd3); #1;
    chk("st_idle_freeze", 32'(bus1.freeze), 1);
    chk("st_idle_we_n", 32'(bus1.SRAM_WE_N), 1);
    chk("st_idle_wb", 32'(bus1.WB_en_out), 0);
    step();
    chk("st_lo_freeze", 32'(bus1.freeze), 1);
    chk("st_lo_we_n", 32'(bus1.SRAM_WE_N), 0);
    chk("st_lo_oe", 32'(bus1.SRAM_DQ_oe), 1);
    chk("st_lo_addr", 32'(bus1.SRAM_ADDR), 0);
    chk("st_lo_dq", 32'(bus1.SRAM_DQ_out), 32'hBEEF);
    step();
    chk("st_hi_freeze", 32'(bus1.freeze), 1);
    chk("st_hi_we_n", 32'(bus1.SRAM_WE_N), 0);
    chk("st_hi_addr", 32'(bus1.SRAM_ADDR), 1);
    chk("st_hi_dq", 32'(bus1.SRAM_DQ_out), 32'hDEAD);
    step();
    chk("st_done_freeze", 32'(bus1.freeze), 0);
    chk("st_done_we_n", 32'(bus1.SRAM_WE_N), 1);
    chk("st_done_oe", 32'(bus1.SRAM_DQ_oe), 0);
    chk("st_done_wb", 32'(bus1.WB_en_out), 1);

    // Load it back
    @(negedge clk); drive1(1, 1, 0, 32'd1024, 0, 5'd9); #1;
    chk("ld_idle_freeze", 32'(bus1.freeze), 1);
    chk("ld_idle_wb", 32'(bus1.WB_en_out), 0);
    step();
    chk("ld_lo_addr", 32'(bus1.SRAM_ADDR), 0);
    chk("ld_lo_we_n", 32'(bus1.SRAM_WE_N), 1);
    chk("ld_lo_wb", 32'(bus1.WB_en_out), 0);
    chk("ld_lo_dest", 32'(bus1.Dest_out), 9);
    step();
    chk("ld_hi_addr", 32'(bus1.SRAM_ADDR), 1);
    chk("ld_hi_freeze", 32'(bus1.freeze), 1);
    step();
    chk("ld_done_val", bus1.Mem_read_value, 32'hDEADBEEF);
    chk("ld_done_wb", 32'(bus1.WB_en_out), 1);
    chk("ld_done_dest", 32'(bus1.Dest_out), 9);
    chk("ld_done_rd", 32'(bus1.MEM_R_EN_out), 1);
    chk("ld_done_freeze", 32'(bus1.freeze), 0);
    chk("sram_lo", 32'(mem1[0]), 32'hBEEF);
    chk("sram_hi", 32'(mem1[1]), 32'hDEAD);

    // Read value holds across an ALU op
    @(negedge clk); drive1(0, 0, 0, 32'h77, 0, 5'd2); #1;
    chk("hold_val", bus1.Mem_read_value, 32'hDEADBEEF);
    chk("hold_alu", bus1.ALU_result_out, 32'h77);
    chk("hold_wb", 32'(bus1.WB_en_out), 0);

    // Reset during HI of a store at 1028
    @(negedge clk); drive1(1, 0, 1, 32'd1028, 32'h11112222, 5'd4); #1;
    step();
    chk("rs_lo_addr", 32'(bus1.SRAM_ADDR), 2);
    chk("rs_lo_dq", 32'(bus1.SRAM_DQ_out), 32'h2222);
    step();
    chk("rs_hi_addr", 32'(bus1.SRAM_ADDR), 3);
    chk("rs_hi_we_n", 32'(bus1.SRAM_WE_N), 0);
    rst = 1'b1;
    drive1(0, 0, 0, 0, 0, 0);
    step();
    chk("rs_freeze", 32'(bus1.freeze), 0);
    chk("rs_we_n", 32'(bus1.SRAM_WE_N), 1);
    chk("rs_oe", 32'(bus1.SRAM_DQ_oe), 0);
    chk("rs_rdval", bus1.Mem_read_value, 0);
    chk("rs_sram_lo", 32'(mem1[2]), 32'h2222);
    rst = 1'b0;
    @(negedge clk); drive1(1, 1, 0, 32'd1024, 0, 5'd6); #1;
    chk("rs_ld_freeze", 32'(bus1.freeze), 1);
    step(); step(); step();
    chk("rs_ld_val", bus1.Mem_read_value, 32'hDEADBEEF);
    chk("rs_ld_freeze_done", 32'(bus1.freeze), 0);

    // R and W together at 1028: serviced as a read
    @(negedge clk); drive1(0, 0, 1, 32'd1028, 32'hC3C35A5A, 5'd0); #1;
    step(); step(); step();
    chk("rw_pre_freeze", 32'(bus1.freeze), 0);
    @(negedge clk); drive1(1, 1, 1, 32'd1028, 32'hFFFFFFFF, 5'd12); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rw_we_n_%0d", i), 32'(bus1.SRAM_WE_N), 1);
      chk($sformatf("rw_oe_%0d", i), 32'(bus1.SRAM_DQ_oe), 0);
      if (i < 3) step();
    end
    chk("rw_val", bus1.Mem_read_value, 32'hC3C35A5A);
    chk("rw_sram_hi", 32'(mem1[3]), 32'hC3C3);
    @(negedge clk); drive1(0, 0, 0, 0, 0, 0);

    // WAIT_CYCLES=3: store then load at 1032 (half-words 4 and 5)
    @(negedge clk); drive3(0, 0, 1, 32'd1032, 32'h9876ABCD, 5'd0); #1;
    for (int i = 0; i < 8; i++) begin
      if (i >= 1 && i <= 3) begin
        chk($sformatf("w3_st_lo_%0d", i), {bus3.SRAM_WE_N, 13'd0, bus3.SRAM_ADDR}, 32'd4);
      end else if (i >= 4 && i <= 6) begin
        chk($sformatf("w3_st_hi_%0d", i), {bus3.SRAM_WE_N, 13'd0, bus3.SRAM_ADDR}, 32'd5);
      end else if (i == 7) begin
        chk("w3_st_done_freeze", 32'(bus3.freeze), 0);
      end
      if (i < 7) step();
    end
    @(negedge clk); drive3(1, 1, 0, 32'd1032, 0, 5'd21); #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w3_ld_freeze_%0d", i), 32'(bus3.freeze), (i < 7) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 3) chk($sformatf("w3_ld_addr_%0d", i), 32'(bus3.SRAM_ADDR), 32'd4);
      if (i >= 4 && i <= 6) chk($sformatf("w3_ld_addr_%0d", i), 32'(bus3.SRAM_ADDR), 32'd5);
      if (i < 7) step();
    end
    chk("w3_ld_val", bus3.Mem_read_value, 32'h9876ABCD);
    chk("w3_ld_dest", 32'(bus3.Dest_out), 21);
    @(negedge clk); drive3(0, 0, 0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
